pwm_seq: RTL and testbench

Period sequencer and compare-value scheduler for the pwmOC output-compare stage.
- Owns the PWM timebase `tb`.
- Accepts duty words from firmware through a valid/ready handshake and double-buffers them.
- Applies first-order fractional dither, then drives `cmpH`/`cmpL` once per period at the wrap boundary.
- Sits between the register/DSP interface and pwmOC; `tb`, `cmpH` and `cmpL` connect directly to pwmOC.

---
 rtl/pwm_seq_pkg.sv | 18 +
 rtl/pwm_dither.sv | 61 ++++++
 rtl/pwm_seq.sv | 119 +++++++++++
 tb/tb_pwm_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_seq_pkg.sv
// Shared constants and types for the PWM period sequencer and its dither stage.
// Duty word layout: {int[WIDTH-1:0], half, frac[FRAC-1:0]}.
package pwm_seq_pkg;
  localparam int SEQ_WIDTH  = 17;
  localparam int SEQ_FRAC   = 8;
  localparam int DUTY_W     = SEQ_WIDTH + 1 + SEQ_FRAC;
  localparam int FRAC_MSB   = SEQ_FRAC - 1;
  localparam int HALF_BIT   = SEQ_FRAC;
  localparam int INT_LSB    = SEQ_FRAC + 1;
  localparam int INT_MSB    = DUTY_W - 1;
  localparam int PERIOD_MIN = 2;

  typedef logic [DUTY_W-1:0] duty_word_t;

  typedef enum logic {ST_IDLE, ST_RUN} seq_state_e;

  typedef enum logic [1:0] {CMP_LOW, CMP_HIGH, CMP_PWM} cmp_mode_e;
endpackage

// File: rtl/pwm_dither.sv
// First-order fractional dither plus compare mapping for pwmOC.
// Compares load only on advance (a timebase wrap); clear forces idle compares.
module pwm_dither
  import pwm_seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH,
  parameter int FRAC  = SEQ_FRAC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  advance,
  input  logic [WIDTH+FRAC:0]   duty,
  input  logic [WIDTH-1:0]      period,
  output logic [WIDTH-1:0]      cmpH,
  output logic [WIDTH:0]        cmpL
);
  logic [FRAC-1:0]  acc;
  logic [FRAC-1:0]  acc_sum;
  logic             carry;
  logic [WIDTH+1:0] d_raw;
  logic [WIDTH+1:0] two_p;
  cmp_mode_e        mode;

  always_comb begin
    {carry, acc_sum} = {1'b0, acc} + {1'b0, duty[FRAC-1:0]};
    d_raw = {1'b0, duty[WIDTH+FRAC:FRAC]} + {{(WIDTH+1){1'b0}}, carry};
    two_p = {1'b0, period, 1'b0};
    mode  = CMP_PWM;
    // Saturate at 2P: anything at or beyond a full period is a constant high.
    if (d_raw >= two_p) begin
      mode = CMP_HIGH;
    end else if (d_raw == '0) begin
      mode = CMP_LOW;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      acc  <= '0;
      cmpH <= WIDTH'(1);
      cmpL <= '0;
    end else if (advance) begin
      acc <= acc_sum;
      case (mode)
        CMP_LOW: begin
          cmpH <= period;
          cmpL <= '0;
        end
        CMP_HIGH: begin
          cmpH <= '0;
          cmpL <= {period, 1'b0};
        end
        default: begin
          cmpH <= '0;
          cmpL <= d_raw[WIDTH:0];
        end
      endcase
    end
  end
endmodule

// File: rtl/pwm_seq.sv
// PWM timebase owner: period register, double-buffered duty words and the
// wrap-aligned hand-off of dithered compare values to pwmOC.
module pwm_seq
  import pwm_seq_pkg::*;
#(
  parameter int          WIDTH      = SEQ_WIDTH,
  parameter int          FRAC       = SEQ_FRAC,
  parameter int unsigned PERIOD_RST = 2**SEQ_WIDTH - 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                period_we,
  input  logic [WIDTH-1:0]    period_in,
  input  logic                duty_valid,
  output logic                duty_ready,
  input  logic [WIDTH+FRAC:0] duty_in,
  output logic [WIDTH-1:0]    tb,
  output logic [WIDTH-1:0]    cmpH,
  output logic [WIDTH:0]      cmpL,
  output logic                period_strobe
);
  localparam logic [WIDTH-1:0] P_MIN = WIDTH'(PERIOD_MIN);
  localparam logic [WIDTH-1:0] P_RST = WIDTH'(PERIOD_RST);

  seq_state_e          state, state_next;
  logic [WIDTH-1:0]    period;
  logic [WIDTH-1:0]    tb_next;
  logic                last_count;
  logic                wrap;
  logic [WIDTH+FRAC:0] shadow, active, dither_word;
  logic                shadow_full;
  logic                ready_en;
  logic                xfer;

  assign last_count    = (state == ST_RUN) && (tb == period - WIDTH'(1));
  assign period_strobe = last_count && en;

  // Handshake: a word moves on any edge with duty_valid && duty_ready; ready
  // means the shadow is empty, so a transfer never overwrites a pending word.
  assign duty_ready  = ready_en && !shadow_full;
  assign xfer        = duty_valid && duty_ready;
  assign dither_word = shadow_full ? shadow : active;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The first enabled edge from idle counts as a wrap so period 0 is loaded.
  always_comb begin
    state_next = state;
    tb_next    = tb;
    wrap       = 1'b0;
    case (state)
      ST_IDLE: begin
        tb_next = '0;
        if (en) begin
          state_next = ST_RUN;
          wrap       = 1'b1;
        end
      end
      default: begin
        if (!en) begin
          state_next = ST_IDLE;
          tb_next    = '0;
        end else if (last_count) begin
          wrap    = 1'b1;
          tb_next = '0;
        end else begin
          tb_next = tb + WIDTH'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tb          <= '0;
      period      <= P_RST;
      active      <= '0;
      shadow      <= '0;
      shadow_full <= 1'b0;
      ready_en    <= 1'b0;
    end else begin
      tb       <= tb_next;
      ready_en <= 1'b1;
      if (period_we && !en) begin
        period <= (period_in < P_MIN) ? P_MIN : period_in;
      end
      if (wrap && shadow_full) begin
        active <= shadow;
      end
      if (xfer) begin
        shadow      <= duty_in;
        shadow_full <= 1'b1;
      end else if (wrap) begin
        shadow_full <= 1'b0;
      end
    end
  end

  pwm_dither #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_dither (
    .clk     (clk),
    .rst     (rst),
    .clear   (!en),
    .advance (wrap),
    .duty    (dither_word),
    .period  (period),
    .cmpH    (cmpH),
    .cmpL    (cmpL)
  );
endmodule

// File: tb/tb_pwm_seq.sv
// Directed bench for pwm_seq: handshake, wrap timing, dither sequence,
// period clamping and mid-run reset, with hand-computed expectations.
module tb_pwm_seq;
  import pwm_seq_pkg::*;

  localparam int W = SEQ_WIDTH;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              period_we;
  logic [W-1:0]      period_in;
  logic              duty_valid;
  logic              duty_ready;
  logic [DUTY_W-1:0] duty_in;
  logic [W-1:0]      tb;
  logic [W-1:0]      cmpH;
  logic [W:0]        cmpL;
  logic              period_strobe;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W:0] exp_q[$];

  pwm_seq dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .period_we     (period_we),
    .period_in     (period_in),
    .duty_valid    (duty_valid),
    .duty_ready    (duty_ready),
    .duty_in       (duty_in),
    .tb            (tb),
    .cmpH          (cmpH),
    .cmpL          (cmpL),
    .period_strobe (period_strobe)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
    end
  endtask

  // driver tasks: inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [DUTY_W-1:0] mk(input int i, input bit h, input int f);
    logic [DUTY_W-1:0] w;
    w = '0;
    w[INT_MSB:INT_LSB] = i[W-1:0];
    w[HALF_BIT]        = h;
    w[FRAC_MSB:0]      = f[SEQ_FRAC-1:0];
    return w;
  endfunction

  task automatic wait_tb(input logic [W-1:0] v, input string tag);
    int n;
    n = 0;
    while (tb !== v && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_reach"}, tb, v);
  endtask

  task automatic send_word(input logic [DUTY_W-1:0] w);
    duty_valid = 1'b1;
    duty_in    = w;
    tick();
    duty_valid = 1'b0;
  endtask

  task automatic load_period(input int p);
    period_we = 1'b1;
    period_in = p[W-1:0];
    tick();
    period_we = 1'b0;
  endtask

  initial begin
    int cnt;
    rst = 1'b0; en = 1'b0; period_we = 1'b0; period_in = '0;
    duty_valid = 1'b0; duty_in = '0;
    @(negedge clk);
    repeat (3) tick();
    check("rst_tb", tb, 0);
    check("rst_cmph", cmpH, 1);
    check("rst_cmpl", cmpL, 0);
    check("rst_ready", duty_ready, 0);
    check("rst_strobe", period_strobe, 0);
    rst = 1'b1;
    tick();
    check("post_rst_ready", duty_ready, 1);

    // 1: period 10, word {3,1,0} accepted at tb=2
    load_period(10);
    en = 1'b1;
    tick();
    check("t1_p0_tb", tb, 0);
    check("t1_p0_cmph", cmpH, 10);
    check("t1_p0_cmpl", cmpL, 0);
    wait_tb(2, "t1_tb2");
    send_word(mk(3, 1'b1, 0));
    check("t1_full_ready", duty_ready, 0);
    check("t1_hold_cmph", cmpH, 10);
    wait_tb(9, "t1_tb9");
    check("t1_strobe", period_strobe, 1);
    tick();
    check("t1_wrap_tb", tb, 0);
    check("t1_wrap_cmph", cmpH, 0);
    check("t1_wrap_cmpl", cmpL, 7);
    check("t1_wrap_ready", duty_ready, 1);
    check("t1_wrap_strobe", period_strobe, 0);
    cnt = 0;
    while (!period_strobe && cnt < 40) begin
      tick();
      cnt++;
    end
    check("t1_strobe_gap", cnt, 9);
    check("t1_strobe_tb", tb, 9);
    tick();
    check("t1_p2_cmpl", cmpL, 7);

    // 2: zero duty then full duty
    send_word(mk(0, 1'b0, 0));
    wait_tb(0, "t2_wrap0");
    check("t2_low_cmph", cmpH, 10);
    check("t2_low_cmpl", cmpL, 0);
    send_word(mk(10, 1'b0, 0));
    wait_tb(9, "t2_tb9");
    check("t2_pre_cmph", cmpH, 10);
    check("t2_pre_cmpl", cmpL, 0);
    tick();
    check("t2_high_cmph", cmpH, 0);
    check("t2_high_cmpl", cmpL, 20);

    // 3: fractional dither, D=6, frac=0x40
    en = 1'b0;
    tick();
    check("t3_idle_tb", tb, 0);
    check("t3_idle_cmph", cmpH, 1);
    check("t3_idle_cmpl", cmpL, 0);
    send_word(mk(3, 1'b0, 'h40));
    en = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(6); exp_q.push_back(6);
      exp_q.push_back(6); exp_q.push_back(7);
    end
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t3_dither%0d", k), cmpL, exp_q.pop_front());
      check($sformatf("t3_cmph%0d", k), cmpH, 0);
      repeat (10) tick();
    end

    // 4: valid held through the strobe with the shadow full
    send_word(mk(2, 1'b0, 0));
    duty_valid = 1'b1;
    duty_in    = mk(5, 1'b0, 0);
    wait_tb(9, "t4_tb9");
    check("t4_strobe", period_strobe, 1);
    check("t4_blocked", duty_ready, 0);
    tick();
    check("t4_wrap_cmpl", cmpL, 4);
    check("t4_wrap_ready", duty_ready, 1);
    tick();
    duty_valid = 1'b0;
    check("t4_accept_ready", duty_ready, 0);
    check("t4_not_yet", cmpL, 4);
    wait_tb(9, "t4_tb9b");
    tick();
    check("t4_next_cmpl", cmpL, 10);

    // 5: period write ignored while running, clamped to 2 while idle
    load_period(1);
    wait_tb(9, "t5_still10");
    en = 1'b0;
    load_period(1);
    check("t5_idle_tb", tb, 0);
    en = 1'b1;
    tick();
    check("t5_p2_tb0", tb, 0);
    tick();
    check("t5_p2_tb1", tb, 1);
    check("t5_p2_strobe", period_strobe, 1);
    tick();
    check("t5_p2_tb0b", tb, 0);
    tick();
    check("t5_p2_tb1b", tb, 1);

    // 6: reset mid-period discards a pending shadow word
    en = 1'b0;
    load_period(10);
    en = 1'b1;
    tick();
    check("t6_active_cmpl", cmpL, 10);
    send_word(mk(1, 1'b0, 0));
    wait_tb(4, "t6_tb4");
    rst = 1'b0;
    tick();
    check("t6_rst_tb", tb, 0);
    check("t6_rst_cmph", cmpH, 1);
    check("t6_rst_cmpl", cmpL, 0);
    check("t6_rst_ready", duty_ready, 0);
    rst = 1'b1;
    en  = 1'b0;
    tick();
    check("t6_rel_ready", duty_ready, 1);
    load_period(10);
    en = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t6_cmph%0d", k), cmpH, 10);
      check($sformatf("t6_cmpl%0d", k), cmpL, 0);
      repeat (10) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
